lfsr_rewind: RTL and testbench
==============================

Name: lfsr_rewind

Overview:
- Sequential inverse of the Galois LFSR single-step used for mine-position generation.
- Given an LFSR state and a step count N, walks the sequence backwards N steps, one step per clock, and returns the state that was N forward steps earlier.
- Used by game setup to regenerate or replay a board from a saved end-of-placement state without storing the seed.
- Embeds the same XAPP052 coefficient table, entries for widths 3..64.

Parameters:
- WIDTH, 16, LFSR width; legal range 3..64.
- CNT_W, 16, width of the step-count input and internal down-counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  cancels an operation in RUN.
- state_in  input  WIDTH  LFSR state to rewind from.
- steps_in  input  CNT_W  number of backward steps N.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; state_out valid.
- state_out  output  WIDTH  rewound state; held until next accepted start.
- zero_err  output  1  loaded state was all-zero (LFSR lock-up state).

Behaviour:
- Inverse step, with c = coeff[WIDTH][WIDTH-1:0] and s = current state:
  - b = s[WIDTH-1]
  - t = s ^ (b ? c : 0)
  - prev = {t[WIDTH-2:0], b}
  - This is exact because c[WIDTH-1] = 1 for every table entry.
  - Pure bitwise logic; no arithmetic on the state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads state_reg <= state_in and cnt <= steps_in, and sets zero_err <= (state_in == 0).
  - If steps_in == 0, go to DONE; else go to RUN.
- RUN:
  - Each cycle: state_reg <= prev(state_reg), cnt <= cnt - 1.
  - When the step with cnt == 1 is taken, go to DONE.
  - abort=1 in RUN: go to IDLE, no step taken that cycle, no done pulse, state_out keeps its last published value.
- DONE:
  - done=1 for exactly one cycle; state_out <= state_reg, published on the same edge that enters DONE.
  - Then go to IDLE.
- Latency: done is high in cycle N+1 after the start-sampling edge. N=0 gives done on the next cycle with state_out = state_in.
- start while busy is ignored, with no queueing. start and done may coincide only when in IDLE, i.e. back-to-back after DONE→IDLE, so minimum issue interval is N+2 cycles.
- abort in IDLE or DONE has no effect.
- All-zero state is a fixed point:
  - Zero input rewinds to zero.
  - zero_err stays high until the next accepted start.
  - Operation still completes normally.
- cnt is unsigned and never wraps; steps_in at max (all ones) runs 2^CNT_W − 1 steps.
- Reset mid-operation: immediately IDLE with busy=0, done=0, state_out=0, zero_err=0, cnt=0.

Optional Feature:
- Macro: LFSR_REWIND_VERIFY_EN.
- Defined:
  - Adds output verify_err (1 bit).
  - Each RUN cycle, the forward step fwd(prev) = (prev>>1) ^ (prev[0] ? c : 0) is compared against the current state_reg.
  - Any mismatch sets verify_err sticky until the next accepted start or reset.
  - Reset value is 0.
- Undefined: the port and comparison logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16, c=16'hD008):
- state_in=16'h8678, steps_in=1, start pulse → done in cycle 2 after start, state_out=16'hACE1, zero_err=0.
- state_in=16'h433C, steps_in=2 → done in cycle 3, state_out=16'hACE1. Intermediate state_reg after the first step is 16'h8678.
- Round trip: run forward lfsr 1000 steps from 16'hACE1 in the bench, rewind with steps_in=1000 → state_out=16'hACE1, done exactly 1001 cycles after start, busy high throughout.
- steps_in=0, state_in=16'h1234 → done next cycle, state_out=16'h1234. Second start asserted while busy is ignored.
- state_in=0, steps_in=5 → zero_err=1, done after 6 cycles, state_out=0.
- steps_in=100, abort at RUN cycle 40 → no done, busy falls next cycle, state_out holds the previous result. rst asserted mid-RUN in a separate run → all outputs 0 the next cycle. With LFSR_REWIND_VERIFY_EN defined, verify_err stays 0 in every scenario.

Source files
------------

// File: rtl/lfsr_rewind.sv
// rtl/lfsr_rewind.sv - walks a right-shift Galois LFSR backwards N steps, one step per clock
//
// Optional build macro: LFSR_REWIND_VERIFY_EN adds the verify_err output.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   start      load state_in/steps_in and begin (accepted in IDLE only)
//   abort      cancel a RUN without publishing a result
//   state_in   LFSR state to rewind from
//   steps_in   number of backward steps N
//   busy       high in RUN and DONE
//   done       one-cycle pulse, state_out valid
//   state_out  rewound state, held until the next published result
//   zero_err   loaded state was all-zero (lock-up state)
//   verify_err (LFSR_REWIND_VERIFY_EN only) sticky forward-check mismatch
module lfsr_rewind #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] state_in,
    input  logic [CNT_W-1:0] steps_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] state_out,
    output logic             zero_err
`ifdef LFSR_REWIND_VERIFY_EN
    ,
    output logic             verify_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    // Tap n of the XAPP052 polynomial lives in coefficient bit n-1.
    function automatic logic [63:0] tap(input int n);
        return 64'd1 << (n - 1);
    endfunction

    function automatic logic [63:0] coeff(input int w);
        logic [63:0] m;
        case (w)
            3:  m = tap(3)  | tap(2);
            4:  m = tap(4)  | tap(3);
            5:  m = tap(5)  | tap(3);
            6:  m = tap(6)  | tap(5);
            7:  m = tap(7)  | tap(6);
            8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  m = tap(9)  | tap(5);
            10: m = tap(10) | tap(7);
            11: m = tap(11) | tap(9);
            12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
            13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
            14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
            15: m = tap(15) | tap(14);
            16: m = tap(16) | tap(15) | tap(13) | tap(4);
            17: m = tap(17) | tap(14);
            18: m = tap(18) | tap(11);
            19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
            20: m = tap(20) | tap(17);
            21: m = tap(21) | tap(19);
            22: m = tap(22) | tap(21);
            23: m = tap(23) | tap(18);
            24: m = tap(24) | tap(23) | tap(22) | tap(17);
            25: m = tap(25) | tap(22);
            26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
            27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
            28: m = tap(28) | tap(25);
            29: m = tap(29) | tap(27);
            30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
            31: m = tap(31) | tap(28);
            32: m = tap(32) | tap(22) | tap(2)  | tap(1);
            33: m = tap(33) | tap(20);
            34: m = tap(34) | tap(27) | tap(2)  | tap(1);
            35: m = tap(35) | tap(33);
            36: m = tap(36) | tap(25);
            37: m = tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
            38: m = tap(38) | tap(6)  | tap(5)  | tap(1);
            39: m = tap(39) | tap(35);
            40: m = tap(40) | tap(38) | tap(21) | tap(19);
            41: m = tap(41) | tap(38);
            42: m = tap(42) | tap(41) | tap(20) | tap(19);
            43: m = tap(43) | tap(42) | tap(38) | tap(37);
            44: m = tap(44) | tap(43) | tap(18) | tap(17);
            45: m = tap(45) | tap(44) | tap(42) | tap(41);
            46: m = tap(46) | tap(45) | tap(26) | tap(25);
            47: m = tap(47) | tap(42);
            48: m = tap(48) | tap(47) | tap(21) | tap(20);
            49: m = tap(49) | tap(40);
            50: m = tap(50) | tap(49) | tap(24) | tap(23);
            51: m = tap(51) | tap(50) | tap(36) | tap(35);
            52: m = tap(52) | tap(49);
            53: m = tap(53) | tap(52) | tap(38) | tap(37);
            54: m = tap(54) | tap(53) | tap(18) | tap(17);
            55: m = tap(55) | tap(31);
            56: m = tap(56) | tap(55) | tap(35) | tap(34);
            57: m = tap(57) | tap(50);
            58: m = tap(58) | tap(39);
            59: m = tap(59) | tap(58) | tap(38) | tap(37);
            60: m = tap(60) | tap(59);
            61: m = tap(61) | tap(60) | tap(46) | tap(45);
            62: m = tap(62) | tap(61) | tap(6)  | tap(5);
            63: m = tap(63) | tap(62);
            64: m = tap(64) | tap(63) | tap(61) | tap(60);
            default: m = 64'd0;
        endcase
        return m;
    endfunction

    localparam logic [63:0]      C_FULL = coeff(WIDTH);
    localparam logic [WIDTH-1:0] C      = C_FULL[WIDTH-1:0];

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] state_out_q, state_out_d;
    logic             zero_err_q, zero_err_d;

    // Inverse step: the forward step shifted the old bit 0 out and, when it
    // was 1, XORed in C whose MSB is always 1. So the current MSB recovers
    // that old bit 0, and undoing the XOR on the low bits recovers the rest.
    logic             back_bit;
    logic [WIDTH-2:0] back_lo;
    logic [WIDTH-1:0] prev;

    assign back_bit = lfsr_q[WIDTH-1];
    assign back_lo  = lfsr_q[WIDTH-2:0] ^ (back_bit ? C[WIDTH-2:0] : '0);
    assign prev     = {back_lo, back_bit};

`ifdef LFSR_REWIND_VERIFY_EN
    logic             verify_err_q, verify_err_d;
    logic [WIDTH-1:0] fwd_of_prev;

    assign fwd_of_prev = (prev >> 1) ^ (prev[0] ? C : '0);
`endif

    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        state_out_d = state_out_q;
        zero_err_d  = zero_err_q;
`ifdef LFSR_REWIND_VERIFY_EN
        verify_err_d = verify_err_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    lfsr_d     = state_in;
                    cnt_d      = steps_in;
                    zero_err_d = (state_in == '0);
`ifdef LFSR_REWIND_VERIFY_EN
                    verify_err_d = 1'b0;
`endif
                    if (steps_in == '0) begin
                        state_out_d = state_in;
                        fsm_d       = DONE;
                    end else begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    fsm_d = IDLE;
                end else begin
                    lfsr_d = prev;
                    cnt_d  = cnt_q - CNT_W'(1);
`ifdef LFSR_REWIND_VERIFY_EN
                    if (fwd_of_prev != lfsr_q) verify_err_d = 1'b1;
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_out_d = prev;
                        fsm_d       = DONE;
                    end
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            lfsr_q      <= '0;
            cnt_q       <= '0;
            state_out_q <= '0;
            zero_err_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            state_out_q <= state_out_d;
            zero_err_q  <= zero_err_d;
        end
    end

`ifdef LFSR_REWIND_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) verify_err_q <= 1'b0;
        else     verify_err_q <= verify_err_d;
    end

    assign verify_err = verify_err_q;
`endif

    assign busy      = (fsm_q != IDLE);
    assign done      = (fsm_q == DONE);
    assign state_out = state_out_q;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_lfsr_rewind.sv
// tb/tb_lfsr_rewind.sv - self-checking bench for lfsr_rewind (WIDTH=16)
module tb_lfsr_rewind;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] state_in;
    logic [15:0] steps_in;
    logic        busy;
    logic        done;
    logic [15:0] state_out;
    logic        zero_err;
`ifdef LFSR_REWIND_VERIFY_EN
    logic        verify_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_rewind #(.WIDTH(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .state_in  (state_in),
        .steps_in  (steps_in),
        .busy      (busy),
        .done      (done),
        .state_out (state_out),
        .zero_err  (zero_err)
`ifdef LFSR_REWIND_VERIFY_EN
        ,
        .verify_err(verify_err)
`endif
    );

    // Forward LFSR step of the generator being inverted.
    function automatic logic [15:0] fwd(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hD008 : 16'h0000);
    endfunction

    function automatic logic [15:0] fwd_n(input logic [15:0] s, input int n);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = fwd(r);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_verify(input string tag);
`ifdef LFSR_REWIND_VERIFY_EN
        check({tag, " verify_err"}, 64'(verify_err), 64'd0);
`endif
    endtask

    // Issue one rewind and check latency, busy, result and zero flag.
    task automatic run_op(input string tag, input logic [15:0] sin, input int n,
                          input logic [15:0] exp_out, input logic exp_zero);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        state_in = sin;
        steps_in = 16'(n);
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc <= n + 5) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(n + 1));
        check({tag, " busy"}, 64'(busy_ok), 64'd1);
        check({tag, " state_out"}, 64'(state_out), 64'(exp_out));
        check({tag, " zero_err"}, 64'(zero_err), 64'(exp_zero));
        check_verify(tag);
        @(negedge clk);
        check({tag, " idle after"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [15:0] seed;
        logic [15:0] prev_res;
        int          n;
        bit          saw_done;

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        state_in = '0;
        steps_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset state_out", 64'(state_out), 64'd0);
        check("reset zero_err", 64'(zero_err), 64'd0);
        check_verify("reset");
        rst = 1'b0;

        run_op("one_step", 16'h8678, 1, 16'hACE1, 1'b0);
        run_op("two_step", 16'h433C, 2, 16'hACE1, 1'b0);
        run_op("mid_step", 16'h433C, 1, 16'h8678, 1'b0);
        run_op("round_trip", fwd_n(16'hACE1, 1000), 1000, 16'hACE1, 1'b0);

        // N=0 with start held into DONE: the second start must be ignored.
        @(negedge clk);
        state_in = 16'h1234;
        steps_in = 16'd0;
        start    = 1'b1;
        @(negedge clk);
        check("n0 done", 64'(done), 64'd1);
        check("n0 state_out", 64'(state_out), 64'h1234);
        state_in = 16'hFFFF;
        steps_in = 16'd3;
        @(negedge clk);
        start = 1'b0;
        check("n0 ignored start", {62'd0, done, busy}, 64'd0);
        check("n0 held", 64'(state_out), 64'h1234);
        @(negedge clk);
        check("n0 still idle", 64'(busy), 64'd0);

        run_op("zero", 16'h0000, 5, 16'h0000, 1'b1);

        for (int k = 0; k < 6; k++) begin
            seed = 16'($urandom_range(1, 65535));
            n    = $urandom_range(1, 40);
            run_op("random", fwd_n(seed, n), n, seed, 1'b0);
        end
        prev_res = state_out;

        // Abort in RUN: no done, nothing published.
        @(negedge clk);
        state_in = 16'h5A5A;
        steps_in = 16'd100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort state_out", 64'(state_out), 64'(prev_res));
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort no done", 64'(saw_done), 64'd0);
        check_verify("abort");

        // Reset mid-RUN with zero_err raised.
        @(negedge clk);
        state_in = 16'h0000;
        steps_in = 16'd50;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset zero_err", 64'(zero_err), 64'd1);
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset state_out", 64'(state_out), 64'd0);
        check("mid reset zero_err", 64'(zero_err), 64'd0);
        check_verify("mid reset");

        run_op("after_reset", 16'h8678, 1, 16'hACE1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
